// File: rtl/axi_ram_wr_queue_if.sv
// AXI write slave front-end: AW command queue, burst engine that turns W beats into
// RAM write commands, and an in-order B response queue. Define AXI_RAM_WR_QUEUE_WRAP_EN for WRAP bursts.
module axi_ram_wr_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int AW_DEPTH   = 4,
    parameter int B_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [ID_WIDTH-1:0]   ram_wr_cmd_id,
    output logic [ADDR_WIDTH-1:0] ram_wr_cmd_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_cmd_data,
    output logic [STRB_WIDTH-1:0] ram_wr_cmd_strb,
    output logic                  ram_wr_cmd_last,
    output logic                  ram_wr_cmd_en,
    input  logic                  ram_wr_cmd_ready,
    output logic                  engine_state
);
    localparam int AW_PW = $clog2(AW_DEPTH);
    localparam int B_PW  = $clog2(B_DEPTH);
    localparam logic [AW_PW:0] AW_FULL = (AW_PW+1)'(AW_DEPTH);
    localparam logic [AW_PW:0] AW_LAST = (AW_PW+1)'(AW_DEPTH - 1);
    localparam logic [B_PW:0]  B_FULL  = (B_PW+1)'(B_DEPTH);
    localparam logic [2:0]     SIZE_MAX = 3'($clog2(STRB_WIDTH));

    typedef enum logic {IDLE, BURST} state_t;
    state_t state;

    // wlast is intentionally ignored: beat count comes from awlen only.
    logic unused_wlast;
    assign unused_wlast = s_axi_wlast;

    // ---------------- AW command queue ----------------
    logic [ID_WIDTH-1:0]   aw_id_mem    [AW_DEPTH];
    logic [ADDR_WIDTH-1:0] aw_addr_mem  [AW_DEPTH];
    logic [7:0]            aw_len_mem   [AW_DEPTH];
    logic [2:0]            aw_size_mem  [AW_DEPTH];
    logic [1:0]            aw_burst_mem [AW_DEPTH];
    logic [AW_PW:0]        aw_wr_ptr, aw_rd_ptr, aw_count, aw_count_next;
    logic                  awready_q, aw_push, aw_pop, aw_nonempty;

    assign s_axi_awready = awready_q && !rst;
    assign aw_push       = s_axi_awvalid && s_axi_awready;
    assign aw_nonempty   = (aw_count != '0);
    assign aw_count_next = aw_count + (AW_PW+1)'(aw_push) - (AW_PW+1)'(aw_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_wr_ptr <= '0;
            aw_rd_ptr <= '0;
            aw_count  <= '0;
            awready_q <= 1'b1;
        end else begin
            if (aw_push) aw_wr_ptr <= aw_wr_ptr + 1'b1;
            if (aw_pop)  aw_rd_ptr <= aw_rd_ptr + 1'b1;
            aw_count <= aw_count_next;
            // Filling the last slot closes awready even if the engine pops this cycle.
            awready_q <= (aw_count_next != AW_FULL) && !(aw_push && aw_count == AW_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (aw_push) begin
            aw_id_mem[aw_wr_ptr[AW_PW-1:0]]    <= s_axi_awid;
            aw_addr_mem[aw_wr_ptr[AW_PW-1:0]]  <= s_axi_awaddr;
            aw_len_mem[aw_wr_ptr[AW_PW-1:0]]   <= s_axi_awlen;
            aw_size_mem[aw_wr_ptr[AW_PW-1:0]]  <= s_axi_awsize;
            aw_burst_mem[aw_wr_ptr[AW_PW-1:0]] <= s_axi_awburst;
        end
    end

    logic [7:0] head_len;
    logic [2:0] head_size;
    logic [1:0] head_burst, load_burst;
    logic       load_err;
    assign head_len   = aw_len_mem[aw_rd_ptr[AW_PW-1:0]];
    assign head_burst = aw_burst_mem[aw_rd_ptr[AW_PW-1:0]];
    assign head_size  = (aw_size_mem[aw_rd_ptr[AW_PW-1:0]] > SIZE_MAX) ? SIZE_MAX
                                                                       : aw_size_mem[aw_rd_ptr[AW_PW-1:0]];
`ifdef AXI_RAM_WR_QUEUE_WRAP_EN
    assign load_burst = head_burst;
    assign load_err   = (head_burst == 2'b11) ||
                        (head_burst == 2'b10 && !(head_len == 8'd1 || head_len == 8'd3 ||
                                                  head_len == 8'd7 || head_len == 8'd15));
`else
    assign load_burst = (head_burst == 2'b10) ? 2'b01 : head_burst;
    assign load_err   = (head_burst == 2'b11);
`endif

    // ---------------- Burst engine ----------------
    logic [7:0]            cnt;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [ADDR_WIDTH-1:0] addr, addr_next, step, incr_addr;
    logic [ID_WIDTH-1:0]   id;
    logic                  err, in_burst, beat_final, beat_acc, b_full;

    assign in_burst   = (state == BURST) && !rst;
    assign beat_final = (cnt == 8'd0);
    assign s_axi_wready = in_burst && ram_wr_cmd_ready && (!beat_final || !b_full);
    assign beat_acc   = s_axi_wvalid && s_axi_wready;
    assign aw_pop     = !rst && aw_nonempty && ((state == IDLE) || (beat_acc && beat_final));

    // A final beat stalled on a full B queue re-presents the same write; repeating it is harmless.
    assign ram_wr_cmd_en   = in_burst && s_axi_wvalid && !err;
    assign ram_wr_cmd_id   = id;
    assign ram_wr_cmd_addr = addr;
    assign ram_wr_cmd_data = s_axi_wdata;
    assign ram_wr_cmd_strb = s_axi_wstrb;
    assign ram_wr_cmd_last = beat_final;
    assign engine_state    = (state == BURST);

    assign step      = ADDR_WIDTH'(1) << size;
    assign incr_addr = (addr & ~(step - 1'b1)) + step;

`ifdef AXI_RAM_WR_QUEUE_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_mask;
    assign addr_next = (burst == 2'b00) ? addr :
                       (burst == 2'b10) ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
    always_ff @(posedge clk) begin
        if (aw_pop) wrap_mask <= ((ADDR_WIDTH'(head_len) + 1'b1) << head_size) - 1'b1;
    end
`else
    assign addr_next = (burst == 2'b00) ? addr : incr_addr;
`endif

    always_ff @(posedge clk) begin
        if (rst)                        state <= IDLE;
        else if (aw_pop)                state <= BURST;
        else if (beat_acc && beat_final) state <= IDLE;
    end

    always_ff @(posedge clk) begin
        if (aw_pop) begin
            cnt   <= head_len;
            size  <= head_size;
            burst <= load_burst;
            addr  <= aw_addr_mem[aw_rd_ptr[AW_PW-1:0]];
            id    <= aw_id_mem[aw_rd_ptr[AW_PW-1:0]];
            err   <= load_err;
        end else if (beat_acc && !beat_final) begin
            cnt  <= cnt - 8'd1;
            addr <= addr_next;
        end
    end

    // ---------------- B response queue ----------------
    logic [ID_WIDTH-1:0] b_id_mem   [B_DEPTH];
    logic [1:0]          b_resp_mem [B_DEPTH];
    logic [B_PW:0]       b_wr_ptr, b_rd_ptr, b_count;
    logic                b_push, b_pop;

    assign b_full       = (b_count == B_FULL);
    assign b_push       = beat_acc && beat_final;
    assign s_axi_bvalid = (b_count != '0) && !rst;
    assign b_pop        = s_axi_bvalid && s_axi_bready;
    assign s_axi_bid    = b_id_mem[b_rd_ptr[B_PW-1:0]];
    assign s_axi_bresp  = b_resp_mem[b_rd_ptr[B_PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            b_wr_ptr <= '0;
            b_rd_ptr <= '0;
            b_count  <= '0;
        end else begin
            if (b_push) b_wr_ptr <= b_wr_ptr + 1'b1;
            if (b_pop)  b_rd_ptr <= b_rd_ptr + 1'b1;
            b_count <= b_count + (B_PW+1)'(b_push) - (B_PW+1)'(b_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (b_push) begin
            b_id_mem[b_wr_ptr[B_PW-1:0]]   <= id;
            b_resp_mem[b_wr_ptr[B_PW-1:0]] <= err ? 2'b10 : 2'b00;
        end
    end
endmodule

// File: tb/tb_axi_ram_wr_queue_if.sv
// Directed scoreboard bench for axi_ram_wr_queue_if: expected RAM commands and B responses
// are queued when stimulus is driven and checked as the DUT produces them.
module tb_axi_ram_wr_queue_if;
    localparam int CW = 61;  // {id, addr, data, strb, last}
    localparam int BW = 10;  // {bid, bresp}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axi_awid = '0;
    logic [15:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = '0;
    logic [1:0]  s_axi_awburst = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [7:0]  ram_wr_cmd_id;
    logic [15:0] ram_wr_cmd_addr;
    logic [31:0] ram_wr_cmd_data;
    logic [3:0]  ram_wr_cmd_strb;
    logic        ram_wr_cmd_last;
    logic        ram_wr_cmd_en;
    logic        ram_wr_cmd_ready = 1'b1;
    logic        engine_state;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int en_cnt = 0;
    int first_en = -1;
    int last_en = -1;
    logic [CW-1:0] exp_cmd_q[$];
    logic [BW-1:0] exp_b_q[$];

    always #5 clk = ~clk;

    axi_ram_wr_queue_if dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .ram_wr_cmd_id(ram_wr_cmd_id), .ram_wr_cmd_addr(ram_wr_cmd_addr),
        .ram_wr_cmd_data(ram_wr_cmd_data), .ram_wr_cmd_strb(ram_wr_cmd_strb),
        .ram_wr_cmd_last(ram_wr_cmd_last), .ram_wr_cmd_en(ram_wr_cmd_en),
        .ram_wr_cmd_ready(ram_wr_cmd_ready), .engine_state(engine_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: a write counts when the W beat is actually consumed.
    always @(negedge clk) begin
        cyc++;
        if (!rst && ram_wr_cmd_en && ram_wr_cmd_ready && s_axi_wready) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (exp_cmd_q.size() == 0) check("ram_cmd_unexpected", 64'd1, 64'd0);
            else check("ram_cmd", {3'b0, ram_wr_cmd_id, ram_wr_cmd_addr, ram_wr_cmd_data,
                                   ram_wr_cmd_strb, ram_wr_cmd_last}, exp_cmd_q.pop_front());
        end
        if (!rst && s_axi_bvalid && s_axi_bready) begin
            if (exp_b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
            else check("b_resp", {s_axi_bid, s_axi_bresp}, exp_b_q.pop_front());
        end
    end

    task automatic exp_cmd(input logic [7:0] id, input logic [15:0] a, input logic [31:0] d,
                           input logic last);
        exp_cmd_q.push_back({id, a, d, 4'hF, last});
    endtask

    task automatic exp_b(input logic [7:0] id, input logic [1:0] resp);
        exp_b_q.push_back({id, resp});
    endtask

    // All drivers start and end at posedge+1.
    task automatic aw_send(input logic [7:0] id, input logic [15:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int g = 0;
        s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_awready && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) check("aw_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic w_stream(input int n, input logic [31:0] base);
        s_axi_wvalid = 1'b1;
        s_axi_wstrb = 4'hF;
        for (int i = 0; i < n; i++) begin
            int g = 0;
            s_axi_wdata = base + 32'(i);
            s_axi_wlast = (i == n - 1);
            @(negedge clk);
            while (!s_axi_wready && g < 200) begin @(negedge clk); g++; end
            if (g >= 200) check("w_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        s_axi_bready = 1'b1;
        while ((exp_cmd_q.size() != 0 || exp_b_q.size() != 0) && g < 300) begin
            @(posedge clk); #1; g++;
        end
        check("drain_done", 64'(g < 300), 64'd1);
    endtask

    initial begin
        int accepted;
        int bv_seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_en", ram_wr_cmd_en, 0);
        check("rst_state", engine_state, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("awready_after_rst", s_axi_awready, 1);
        @(posedge clk); #1;

        // Single beat, bvalid one cycle after the final beat
        exp_cmd(8'h11, 16'h0010, 32'hA5A5A5A5, 1'b1);
        exp_b(8'h11, 2'b00);
        aw_send(8'h11, 16'h0010, 8'd0, 3'd2, 2'b01);
        w_stream(1, 32'hA5A5A5A5);
        @(negedge clk);
        check("b_latency", s_axi_bvalid, 1);
        @(posedge clk); #1;
        drain();

        // Back-to-back INCR bursts with no bubble
        en_cnt = 0; first_en = -1;
        for (int i = 0; i < 4; i++) exp_cmd(8'h01, 16'(4 * i), 32'h1000 + 32'(i), i == 3);
        for (int i = 0; i < 4; i++) exp_cmd(8'h02, 16'h0100 + 16'(4 * i), 32'h1004 + 32'(i), i == 3);
        exp_b(8'h01, 2'b00);
        exp_b(8'h02, 2'b00);
        aw_send(8'h01, 16'h0000, 8'd3, 3'd2, 2'b01);
        aw_send(8'h02, 16'h0100, 8'd3, 3'd2, 2'b01);
        w_stream(8, 32'h1000);
        drain();
        check("b2b_beats", en_cnt, 8);
        check("b2b_span", last_en - first_en + 1, 8);

        // WRAP burst
        exp_cmd(8'h03, 16'h0038, 32'h2000, 1'b0);
        exp_cmd(8'h03, 16'h003C, 32'h2001, 1'b0);
`ifdef AXI_RAM_WR_QUEUE_WRAP_EN
        exp_cmd(8'h03, 16'h0030, 32'h2002, 1'b0);
        exp_cmd(8'h03, 16'h0034, 32'h2003, 1'b1);
`else
        exp_cmd(8'h03, 16'h0040, 32'h2002, 1'b0);
        exp_cmd(8'h03, 16'h0044, 32'h2003, 1'b1);
`endif
        exp_b(8'h03, 2'b00);
        aw_send(8'h03, 16'h0038, 8'd3, 3'd2, 2'b10);
        w_stream(4, 32'h2000);
        drain();

        // awsize larger than the bus clamps to 4 bytes; unaligned start aligns on the next beat
        exp_cmd(8'h04, 16'h0201, 32'h2100, 1'b0);
        exp_cmd(8'h04, 16'h0204, 32'h2101, 1'b1);
        exp_b(8'h04, 2'b00);
        aw_send(8'h04, 16'h0201, 8'd1, 3'd3, 2'b01);
        w_stream(2, 32'h2100);
        // FIXED keeps the address
        for (int i = 0; i < 3; i++) exp_cmd(8'h05, 16'h0300, 32'h2200 + 32'(i), i == 2);
        exp_b(8'h05, 2'b00);
        aw_send(8'h05, 16'h0300, 8'd2, 3'd2, 2'b00);
        w_stream(3, 32'h2200);
        drain();

        // Reserved burst type: beats consumed, no RAM writes, SLVERR
        en_cnt = 0;
        exp_b(8'h06, 2'b10);
        aw_send(8'h06, 16'h0400, 8'd1, 3'd2, 2'b11);
        w_stream(2, 32'h2300);
        drain();
        check("err_no_en", en_cnt, 0);

        // AW queue full: the engine holds one command, the queue holds AW_DEPTH more
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            s_axi_awid = 8'h20 + 8'(i); s_axi_awaddr = 16'(16 * i); s_axi_awlen = 8'd0;
            s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
            @(negedge clk);
            if (!s_axi_awready) break;
            accepted++;
            exp_cmd(8'h20 + 8'(i), 16'(16 * i), 32'h3000 + 32'(i), 1'b1);
            exp_b(8'h20 + 8'(i), 2'b00);
            @(posedge clk); #1;
        end
        s_axi_awvalid = 1'b0;
        check("aw_accepted", accepted, 5);
        check("aw_full_awready", s_axi_awready, 0);
        @(posedge clk); #1;
        w_stream(1, 32'h3000);
        @(negedge clk);
        check("aw_reopen", s_axi_awready, 1);
        @(posedge clk); #1;
        w_stream(4, 32'h3001);
        drain();

        // B backpressure: fifth final beat waits for B space
        s_axi_bready = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            exp_cmd(8'h30 + 8'(i), 16'h0500 + 16'(4 * i), 32'h4000 + 32'(i), 1'b1);
            exp_b(8'h30 + 8'(i), 2'b00);
            aw_send(8'h30 + 8'(i), 16'h0500 + 16'(4 * i), 8'd0, 3'd2, 2'b01);
        end
        w_stream(4, 32'h4000);
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h4004; s_axi_wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_full_wready", s_axi_wready, 0);
        end
        check("b_full_beats", en_cnt, 4);
        check("b_full_bvalid", s_axi_bvalid, 1);
        @(posedge clk); #1; s_axi_bready = 1'b1;
        @(posedge clk); #1; s_axi_bready = 1'b0;
        begin
            int g = 0;
            @(negedge clk);
            while (!s_axi_wready && g < 50) begin @(negedge clk); g++; end
            check("b_pulse_reopen", 64'(g < 50), 64'd1);
        end
        @(posedge clk); #1; s_axi_wvalid = 1'b0;
        drain();

        // Reset in the middle of a burst drops everything
        exp_cmd(8'h40, 16'h0600, 32'h5000, 1'b0);
        exp_cmd(8'h40, 16'h0604, 32'h5001, 1'b0);
        aw_send(8'h40, 16'h0600, 8'd3, 3'd2, 2'b01);
        aw_send(8'h41, 16'h0700, 8'd0, 3'd2, 2'b01);
        w_stream(2, 32'h5000);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_bvalid", s_axi_bvalid, 0);
        check("mid_rst_awready", s_axi_awready, 0);
        check("mid_rst_wready", s_axi_wready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", s_axi_awready, 1);
        check("post_rst_state", engine_state, 0);
        bv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_axi_bvalid) bv_seen++;
        end
        check("post_rst_no_b", bv_seen, 0);
        @(posedge clk); #1;

        // Normal operation after reset
        exp_cmd(8'h50, 16'h0800, 32'h6000, 1'b1);
        exp_b(8'h50, 2'b00);
        aw_send(8'h50, 16'h0800, 8'd0, 3'd2, 2'b01);
        w_stream(1, 32'h6000);
        drain();

        check("cmd_q_empty", exp_cmd_q.size(), 0);
        check("b_q_empty", exp_b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
